// File: rtl/window_accumulator.sv
// Multi-channel windowed accumulator: sums `de`-qualified samples per channel over a
// programmable window and emits one registered sum per channel when the window closes.
module window_accumulator #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned INPUT_WIDTH    = 18,
  parameter int unsigned OUTPUT_WIDTH   = 24,
  parameter int unsigned COUNTER_LENGTH = 8,
  parameter bit          SIGNED         = 1'b0,
  parameter bit          SATURATE       = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]    inputValue,
  input  logic                               de,
  input  logic [COUNTER_LENGTH-1:0]          length,
  input  logic                               flush,
  output logic [CHANNELS*OUTPUT_WIDTH-1:0]   valueOut,
  output logic                               deOut,
  output logic                               partialOut,
  output logic [CHANNELS-1:0]                overflowOut,
  output logic [COUNTER_LENGTH-1:0]          counterOut
);

  localparam int unsigned IW = INPUT_WIDTH;
  localparam int unsigned OW = OUTPUT_WIDTH;
  localparam int unsigned CW = COUNTER_LENGTH;
  localparam int unsigned SW = OUTPUT_WIDTH + 1;

  logic [CHANNELS*OW-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          len_q, len_d;
  logic [CHANNELS*OW-1:0] value_q, value_d;
  logic                   de_out_q, de_out_d;
  logic                   partial_q, partial_d;
  logic [CHANNELS-1:0]    ovf_out_q, ovf_out_d;

  logic [CHANNELS*OW-1:0] sum_c;
  logic [CHANNELS-1:0]    ovf_now_c;
  logic [SW-1:0]          full_c [CHANNELS];
  logic [SW-1:0]          ext_c  [CHANNELS];
  logic [SW-1:0]          acc_ext_c [CHANNELS];
  logic [IW-1:0]          sample_c [CHANNELS];
  logic [OW-1:0]          acc_ch_c [CHANNELS];
  logic                   start_c;
  logic [CW-1:0]          len_eff_c;
  logic [CW-1:0]          cnt_inc_c;
  logic                   close_c;
  logic                   emit_c;

  // Per-channel full-precision add, overflow detection and clamp/wrap
  always_comb begin
    sum_c     = '0;
    ovf_now_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sample_c[c] = inputValue[c*IW +: IW];
      acc_ch_c[c] = acc_q[c*OW +: OW];
      if (SIGNED) begin
        ext_c[c]     = {{(SW-IW){sample_c[c][IW-1]}}, sample_c[c]};
        acc_ext_c[c] = {acc_ch_c[c][OW-1], acc_ch_c[c]};
      end else begin
        ext_c[c]     = {{(SW-IW){1'b0}}, sample_c[c]};
        acc_ext_c[c] = {1'b0, acc_ch_c[c]};
      end
      full_c[c] = acc_ext_c[c] + (de ? ext_c[c] : SW'(0));
      if (SIGNED) ovf_now_c[c] = full_c[c][SW-1] ^ full_c[c][SW-2];
      else        ovf_now_c[c] = full_c[c][SW-1];
      if (ovf_now_c[c] && SATURATE) begin
        if (!SIGNED)               sum_c[c*OW +: OW] = '1;
        else if (full_c[c][SW-1])  sum_c[c*OW +: OW] = {1'b1, {(OW-1){1'b0}}};
        else                       sum_c[c*OW +: OW] = {1'b0, {(OW-1){1'b1}}};
      end else begin
        sum_c[c*OW +: OW] = full_c[c][OW-1:0];
      end
    end
  end

  // Window control: length latch at first sample, close/flush decisions, next state
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    value_d   = '0;
    de_out_d  = 1'b0;
    partial_d = 1'b0;
    ovf_out_d = '0;

    start_c   = (cnt_q == '0);
    len_eff_c = start_c ? ((length == '0) ? CW'(1) : length) : len_q;
    cnt_inc_c = cnt_q + CW'(1);
    close_c   = de && (cnt_inc_c == len_eff_c);
    emit_c    = close_c || (flush && (de || !start_c));

    if (de && start_c) len_d = len_eff_c;

    if (emit_c) begin
      value_d   = sum_c;
      de_out_d  = 1'b1;
      partial_d = !close_c;
      ovf_out_d = ovf_q | (de ? ovf_now_c : '0);
      acc_d     = '0;
      ovf_d     = '0;
      cnt_d     = '0;
    end else if (de) begin
      acc_d = sum_c;
      ovf_d = ovf_q | ovf_now_c;
      cnt_d = cnt_inc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      value_q   <= '0;
      de_out_q  <= 1'b0;
      partial_q <= 1'b0;
      ovf_out_q <= '0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      value_q   <= value_d;
      de_out_q  <= de_out_d;
      partial_q <= partial_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign valueOut    = value_q;
  assign deOut       = de_out_q;
  assign partialOut  = partial_q;
  assign overflowOut = ovf_out_q;
  assign counterOut  = cnt_q;

endmodule

// File: tb/tb_window_accumulator.sv
// Scoreboard bench for window_accumulator: default, 8-bit saturating and signed-wrap instances.
module tb_window_accumulator;

  typedef struct {
    logic [95:0] val;
    logic        part;
    logic [3:0]  ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_m[$], q_s[$], q_g[$];

  logic [71:0] m_in = '0;  logic m_de = 0, m_flush = 0;  logic [7:0] m_len = '0;
  logic [95:0] m_val;      logic m_deo, m_part;  logic [3:0] m_ovf;  logic [7:0] m_cnt;
  logic [31:0] s_in = '0;  logic s_de = 0, s_flush = 0;  logic [7:0] s_len = '0;
  logic [31:0] s_val;      logic s_deo, s_part;  logic [3:0] s_ovf;  logic [7:0] s_cnt;
  logic [71:0] g_in = '0;  logic g_de = 0, g_flush = 0;  logic [7:0] g_len = '0;
  logic [95:0] g_val;      logic g_deo, g_part;  logic [3:0] g_ovf;  logic [7:0] g_cnt;

  window_accumulator u_main (
    .clk(clk), .reset(reset), .inputValue(m_in), .de(m_de), .length(m_len), .flush(m_flush),
    .valueOut(m_val), .deOut(m_deo), .partialOut(m_part), .overflowOut(m_ovf), .counterOut(m_cnt));

  window_accumulator #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(8)) u_sat8 (
    .clk(clk), .reset(reset), .inputValue(s_in), .de(s_de), .length(s_len), .flush(s_flush),
    .valueOut(s_val), .deOut(s_deo), .partialOut(s_part), .overflowOut(s_ovf), .counterOut(s_cnt));

  window_accumulator #(.SIGNED(1'b1), .SATURATE(1'b0)) u_sgn (
    .clk(clk), .reset(reset), .inputValue(g_in), .de(g_de), .length(g_len), .flush(g_flush),
    .valueOut(g_val), .deOut(g_deo), .partialOut(g_part), .overflowOut(g_ovf), .counterOut(g_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output appears after the posedge that accepts the currently driven inputs
  task automatic push(input int id, input logic [95:0] v, input logic p, input logic [3:0] o);
    exp_t e;
    e = '{val: v, part: p, ovf: o, cyc: cyc + 1};
    case (id)
      0:       q_m.push_back(e);
      1:       q_s.push_back(e);
      default: q_g.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input string nm, input logic deo, input logic [95:0] v,
                     input logic p, input logic [3:0] o);
    exp_t e;
    int   n;
    checks++;
    if (deo !== 1'b1) begin
      if (deo !== 1'b0 || v !== '0 || p !== 1'b0 || o !== '0) begin
        errors++;
        $display("FAIL %s idle: deOut=%b val=%h part=%b ovf=%b, want all 0", nm, deo, v, p, o);
      end
      return;
    end
    case (id)
      0:       n = q_m.size();
      1:       n = q_s.size();
      default: n = q_g.size();
    endcase
    if (n == 0) begin
      errors++;
      $display("FAIL %s unexpected deOut at cycle %0d: val=%h part=%b ovf=%b", nm, cyc, v, p, o);
      return;
    end
    case (id)
      0:       e = q_m.pop_front();
      1:       e = q_s.pop_front();
      default: e = q_g.pop_front();
    endcase
    if (v !== e.val || p !== e.part || o !== e.ovf || cyc != e.cyc) begin
      errors++;
      $display("FAIL %s window: got val=%h part=%b ovf=%b cyc=%0d, want val=%h part=%b ovf=%b cyc=%0d",
               nm, v, p, o, cyc, e.val, e.part, e.ovf, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "main", m_deo, m_val, m_part, m_ovf);
    mon(1, "sat8", s_deo, 96'(s_val), s_part, s_ovf);
    mon(2, "sgn", g_deo, g_val, g_part, g_ovf);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic drv_m(input logic d, input logic f, input logic [7:0] l,
                       input logic [17:0] a, input logic [17:0] b, input logic [17:0] c, input logic [17:0] e);
    @(negedge clk);
    m_de = d; m_flush = f; m_len = l; m_in = {e, c, b, a};
  endtask

  task automatic idle_m(input int n);
    for (int i = 0; i < n; i++) drv_m(1'b0, 1'b0, m_len, 18'd0, 18'd0, 18'd0, 18'd0);
  endtask

  function automatic logic [95:0] p24(input logic [23:0] a, input logic [23:0] b,
                                      input logic [23:0] c, input logic [23:0] d);
    return {d, c, b, a};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset counter", 32'(m_cnt), 32'd0);
    reset = 1'b0;

    // 9-sample window, per-channel distinct samples
    for (int i = 0; i < 9; i++) begin
      drv_m(1'b1, 1'b0, 8'd9, 18'd1, 18'd2, 18'd3, 18'd4);
      if (i == 8) push(0, p24(24'd9, 24'd18, 24'd27, 24'd36), 1'b0, 4'b0000);
    end
    idle_m(2);
    chk("counter after close", 32'(m_cnt), 32'd0);

    // Back-to-back windows of 3
    for (int i = 0; i < 12; i++) begin
      drv_m(1'b1, 1'b0, 8'd3, 18'd1, 18'd1, 18'd1, 18'd1);
      if (i % 3 == 2) push(0, p24(24'd3, 24'd3, 24'd3, 24'd3), 1'b0, 4'b0000);
    end
    idle_m(2);

    // Flush of a partial window with de low
    for (int i = 0; i < 5; i++) drv_m(1'b1, 1'b0, 8'd8, 18'd2, 18'd2, 18'd2, 18'd2);
    idle_m(1);
    chk("counter before flush", 32'(m_cnt), 32'd5);
    drv_m(1'b0, 1'b1, 8'd8, 18'd0, 18'd0, 18'd0, 18'd0);
    push(0, p24(24'd10, 24'd10, 24'd10, 24'd10), 1'b1, 4'b0000);
    idle_m(1);
    chk("counter after flush", 32'(m_cnt), 32'd0);

    // Mid-window length change is ignored
    drv_m(1'b1, 1'b0, 8'd4, 18'd1, 18'd1, 18'd1, 18'd1);
    for (int i = 0; i < 3; i++) begin
      drv_m(1'b1, 1'b0, 8'd2, 18'd1, 18'd1, 18'd1, 18'd1);
      if (i == 2) push(0, p24(24'd4, 24'd4, 24'd4, 24'd4), 1'b0, 4'b0000);
    end
    idle_m(2);

    // Length 0 behaves as 1
    for (int i = 0; i < 2; i++) begin
      drv_m(1'b1, 1'b0, 8'd0, 18'd5, 18'd6, 18'd7, 18'd8);
      push(0, p24(24'd5, 24'd6, 24'd7, 24'd8), 1'b0, 4'b0000);
    end
    idle_m(2);

    // Flush with de high: partial, then completing
    drv_m(1'b1, 1'b0, 8'd4, 18'd1, 18'd2, 18'd3, 18'd4);
    drv_m(1'b1, 1'b0, 8'd4, 18'd1, 18'd2, 18'd3, 18'd4);
    drv_m(1'b1, 1'b1, 8'd4, 18'd1, 18'd2, 18'd3, 18'd4);
    push(0, p24(24'd3, 24'd6, 24'd9, 24'd12), 1'b1, 4'b0000);
    drv_m(1'b1, 1'b0, 8'd3, 18'd1, 18'd1, 18'd1, 18'd1);
    drv_m(1'b1, 1'b0, 8'd3, 18'd1, 18'd1, 18'd1, 18'd1);
    drv_m(1'b1, 1'b1, 8'd3, 18'd1, 18'd1, 18'd1, 18'd1);
    push(0, p24(24'd3, 24'd3, 24'd3, 24'd3), 1'b0, 4'b0000);
    // Flush of an empty window produces nothing
    drv_m(1'b0, 1'b1, 8'd3, 18'd0, 18'd0, 18'd0, 18'd0);
    idle_m(3);

    // Reset mid-window discards the partial sums
    for (int i = 0; i < 4; i++) drv_m(1'b1, 1'b0, 8'd9, 18'd5, 18'd5, 18'd5, 18'd5);
    drv_m(1'b0, 1'b0, 8'd9, 18'd0, 18'd0, 18'd0, 18'd0);
    reset = 1'b1;
    idle_m(2);
    reset = 1'b0;
    chk("counter after reset", 32'(m_cnt), 32'd0);
    for (int i = 0; i < 9; i++) begin
      drv_m(1'b1, 1'b0, 8'd9, 18'd1, 18'd1, 18'd1, 18'd1);
      if (i == 8) push(0, p24(24'd9, 24'd9, 24'd9, 24'd9), 1'b0, 4'b0000);
    end
    idle_m(2);

    // Unsigned saturation at 8 bits on channel 0 only, then sticky bit cleared
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_de = 1'b1; s_len = 8'd4; s_in = {8'd10, 8'd10, 8'd10, 8'd100};
      if (i == 3) push(1, 96'({8'd40, 8'd40, 8'd40, 8'd255}), 1'b0, 4'b0001);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_de = 1'b1; s_len = 8'd2; s_in = {8'd1, 8'd1, 8'd1, 8'd1};
      if (i == 1) push(1, 96'({8'd2, 8'd2, 8'd2, 8'd2}), 1'b0, 4'b0000);
    end
    @(negedge clk);
    s_de = 1'b0;
    repeat (2) @(negedge clk);

    // Signed, wrapping: -5+3, 3-5, 100-1, -100-100
    @(negedge clk);
    g_de = 1'b1; g_len = 8'd2;
    g_in = {18'(-100), 18'd100, 18'd3, 18'(-5)};
    @(negedge clk);
    g_in = {18'(-100), 18'(-1), 18'(-5), 18'd3};
    push(2, p24(24'(-2), 24'(-2), 24'd99, 24'(-200)), 1'b0, 4'b0000);
    // 65 x 131071 exceeds the signed 24-bit max on channel 0 and wraps
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      g_de = 1'b1; g_len = 8'd65; g_in = {18'd0, 18'd0, 18'd0, 18'h1FFFF};
      if (i == 64) push(2, p24(24'h81FFBF, 24'd0, 24'd0, 24'd0), 1'b0, 4'b0001);
    end
    @(negedge clk);
    g_de = 1'b0;
    repeat (4) @(negedge clk);

    chk("main queue drained", 32'(q_m.size()), 32'd0);
    chk("sat8 queue drained", 32'(q_s.size()), 32'd0);
    chk("sgn queue drained", 32'(q_g.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
